// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection phase sequencer.
// Phase order in the enum is the cyclic sequence order.
package traffic_pkg;

  typedef enum logic [2:0] {
    ALLRED_M    = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_YELLOW = 3'd2,
    ALLRED_S    = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5
  } phase_e;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
  } light_pair_t;

  function automatic light_pair_t light_pair(input phase_e s);
    light_pair_t p;
    p.main = LIGHT_R;
    p.side = LIGHT_R;
    case (s)
      MAIN_GREEN:  p.main = LIGHT_G;
      MAIN_YELLOW: p.main = LIGHT_Y;
      SIDE_GREEN:  p.side = LIGHT_G;
      SIDE_YELLOW: p.side = LIGHT_Y;
      default:     ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating tick counter: counts enabled ticks up to Tc and holds there.
// Done is high while the count sits at the terminal value.
module phase_timer #(
  parameter int CW = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Clr,
  input  logic          En,
  input  logic [CW-1:0] Tc,
  output logic          Done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Rst || Clr)
      cnt <= '0;
    else if (En && (cnt != Tc))
      cnt <= cnt + 1'b1;
  end

  assign Done = (cnt == Tc);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer with pedestrian walk on side green.
// State is exposed on State for observation; lights, Walk and PedAck are registered.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int SIDE_T   = 4,
  parameter int WALK_T   = 3,
  parameter int CW       = 4
) (
  input  logic   Clk,
  input  logic   Rst,
  input  logic   En,
  input  logic   SideCar,
  input  logic   PedReq,
  output logic   [0:2] MainLight,
  output logic   [0:2] SideLight,
  output logic   Walk,
  output logic   PedAck,
  output phase_e State
);

  if (GREEN_T < 1 || YELLOW_T < 1 || ALLRED_T < 1 || SIDE_T < 1 || WALK_T < 1 ||
      WALK_T > SIDE_T || CW < 1 || CW > 30 ||
      GREEN_T > (1 << CW) || YELLOW_T > (1 << CW) || ALLRED_T > (1 << CW) ||
      SIDE_T > (1 << CW)) begin : g_param_check
    $error("traffic_phase_ctrl: illegal timing parameters");
  end

  localparam logic [CW-1:0] TC_GREEN  = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] TC_YELLOW = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] TC_ALLRED = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] TC_SIDE   = CW'(SIDE_T - 1);
  localparam logic [CW-1:0] TC_WALK   = CW'(WALK_T - 1);

  phase_e        state, state_n;
  logic          pend;
  logic [CW-1:0] tc;
  logic          phase_done, walk_done;
  logic          go, enter_side, walk_n;

  always_comb begin
    tc         = TC_ALLRED;
    state_n    = state;
    go         = 1'b0;
    enter_side = 1'b0;
    walk_n     = Walk;
    case (state)
      MAIN_GREEN:  tc = TC_GREEN;
      MAIN_YELLOW: tc = TC_YELLOW;
      SIDE_GREEN:  tc = TC_SIDE;
      SIDE_YELLOW: tc = TC_YELLOW;
      default:     tc = TC_ALLRED;
    endcase
    // Main green is held, timer saturated, until there is demand for the side.
    go = En && phase_done && ((state != MAIN_GREEN) || SideCar || pend);
    if (go) begin
      case (state)
        ALLRED_M:    state_n = MAIN_GREEN;
        MAIN_GREEN:  state_n = MAIN_YELLOW;
        MAIN_YELLOW: state_n = ALLRED_S;
        ALLRED_S:    state_n = SIDE_GREEN;
        SIDE_GREEN:  state_n = SIDE_YELLOW;
        default:     state_n = ALLRED_M;
      endcase
    end
    enter_side = go && (state == ALLRED_S);
    // A press arriving on the entry edge is served in this phase as well.
    if (enter_side)
      walk_n = pend || PedReq;
    else if (go)
      walk_n = 1'b0;
    else if (Walk && En && walk_done)
      walk_n = 1'b0;
  end

  phase_timer #(.CW(CW)) u_phase_timer (
    .Clk  (Clk),
    .Rst  (Rst),
    .Clr  (go),
    .En   (En),
    .Tc   (tc),
    .Done (phase_done)
  );

  phase_timer #(.CW(CW)) u_walk_timer (
    .Clk  (Clk),
    .Rst  (Rst),
    .Clr  (enter_side),
    .En   (En && Walk),
    .Tc   (TC_WALK),
    .Done (walk_done)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ALLRED_M;
      pend      <= 1'b0;
      Walk      <= 1'b0;
      PedAck    <= 1'b0;
      MainLight <= LIGHT_R;
      SideLight <= LIGHT_R;
    end else begin
      state                  <= state_n;
      pend                   <= PedReq || (pend && !enter_side);
      Walk                   <= walk_n;
      PedAck                 <= enter_side && walk_n;
      {MainLight, SideLight} <= light_pair(state_n);
    end
  end

  assign State = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized and directed bench for traffic_phase_ctrl with a tick-level
// reference model feeding an expected-output queue checked by a monitor.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int GREEN_T  = 4;
  localparam int YELLOW_T = 2;
  localparam int ALLRED_T = 1;
  localparam int SIDE_T   = 3;
  localparam int WALK_T   = 2;
  localparam int CW       = 4;
  localparam int W        = 11;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic side_car = 1'b0;
  logic ped_req = 1'b0;
  logic [0:2] main_light, side_light;
  logic walk, ped_ack;
  phase_e state;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T),
    .SIDE_T(SIDE_T), .WALK_T(WALK_T), .CW(CW)
  ) dut (
    .Clk       (clk),
    .Rst       (rst),
    .En        (en),
    .SideCar   (side_car),
    .PedReq    (ped_req),
    .MainLight (main_light),
    .SideLight (side_light),
    .Walk      (walk),
    .PedAck    (ped_ack),
    .State     (state)
  );

  // reference model: phase index in cyclic order, ticks spent, walk ticks left
  int m_ph = 0;
  int m_el = 0;
  bit m_pend = 0;
  int m_walk_left = 0;
  bit m_ack = 0;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic int dur(input int ph);
    case (ph)
      1:       return GREEN_T;
      2, 5:    return YELLOW_T;
      4:       return SIDE_T;
      default: return ALLRED_T;
    endcase
  endfunction

  function automatic logic [5:0] lights(input int ph);
    case (ph)
      1:       return 6'b001_100;
      2:       return 6'b010_100;
      4:       return 6'b100_001;
      5:       return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  // driver: apply one cycle of inputs and predict the outputs after that edge
  task automatic step(input bit r, input bit e, input bit sc, input bit pr);
    bit adv, entering;
    @(negedge clk);
    rst = r; en = e; side_car = sc; ped_req = pr;
    if (r) begin
      m_ph = 0; m_el = 0; m_pend = 0; m_walk_left = 0; m_ack = 0;
    end else begin
      adv = 0;
      m_ack = 0;
      if (e) begin
        if (m_el + 1 >= dur(m_ph) && (m_ph != 1 || sc || m_pend)) adv = 1;
        else if (m_el + 1 < dur(m_ph)) m_el++;
        if (m_walk_left > 0) m_walk_left--;
      end
      entering = adv && (m_ph == 3);
      if (adv) begin
        if (entering && (m_pend || pr)) begin
          m_walk_left = WALK_T;
          m_ack = 1;
        end else if (m_ph == 4) begin
          m_walk_left = 0;
        end
        m_ph = (m_ph + 1) % 6;
        m_el = 0;
      end
      m_pend = pr || (m_pend && !entering);
    end
    exp_q.push_back({lights(m_ph), m_walk_left > 0, m_ack, 3'(m_ph)});
  endtask

  task automatic run(input int n, input bit sc);
    for (int i = 0; i < n; i++) step(0, 1, sc, 0);
  endtask

  task automatic run_to_ph(input int ph, input bit sc);
    int guard = 0;
    while (m_ph != ph && guard < 200) begin
      step(0, 1, sc, 0);
      guard++;
    end
    if (m_ph != ph) begin
      n_vec++; n_bad++;
      $display("FAIL run_to_ph: model phase %0d, required %0d", m_ph, ph);
    end
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [W-1:0] e, g;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {main_light, side_light, walk, ped_ack, 3'(state)};
      n_vec++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL outputs @%0t: got main=%b side=%b walk=%b ack=%b st=%0d, exp main=%b side=%b walk=%b ack=%b st=%0d",
                 $time, g[10:8], g[7:5], g[4], g[3], g[2:0], e[10:8], e[7:5], e[4], e[3], e[2:0]);
      end
      n_vec++;
      if (main_light != LIGHT_R && side_light != LIGHT_R) begin
        n_bad++;
        $display("FAIL safety @%0t: main=%b side=%b both non-red", $time, main_light, side_light);
      end
    end
  end

  initial begin
    bit sc;
    // 1: reset, then idle main green
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    run(51, 0);
    // 2: side car waiting, full cycle
    run(14, 1);
    run_to_ph(1, 0);
    run(5, 0);
    // 3: single pedestrian press during held main green
    step(0, 1, 0, 1);
    run(20, 0);
    // 4: press on the side-green entry edge
    run_to_ph(3, 1);
    step(0, 1, 0, 1);
    run(25, 0);
    // 5: half-rate ticks, press latched on a frozen cycle
    for (int i = 0; i < 40; i++) step(0, (i % 2) == 0, i < 20, i == 25);
    for (int i = 0; i < 30; i++) step(0, (i % 2) == 0, 0, 0);
    // 6: reset during walk
    run_to_ph(1, 0);
    step(0, 1, 0, 1);
    run_to_ph(4, 0);
    step(1, 1, 0, 0);
    run(12, 0);
    // random soak
    sc = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) sc = ~sc;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, sc,
           $urandom_range(0, 24) == 0);
    end
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
